// File: rtl/riscv_test_sequencer.sv
// Self-check sequencer for the single-cycle core: reset hold, bounded run, regfile compare.
// Ports: clk/reset, start, exp_* table load, core_reset/dbg_reg_* to core, status outputs.
// Optional: define RISCV_SEQ_HALT_PC_EN to add core_pc/halt_pc early-halt on PC match.
module riscv_test_sequencer #(
`ifdef RISCV_SEQ_HALT_PC_EN
    parameter int PC_W         = 32,
`endif
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_CHECKS   = 16,
    parameter int IDX_W        = 4,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 20,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  exp_we,
    input  logic [IDX_W-1:0]      exp_idx,
    input  logic                  exp_valid,
    input  logic [REG_ADDR_W-1:0] exp_addr,
    input  logic [XLEN-1:0]       exp_data,
`ifdef RISCV_SEQ_HALT_PC_EN
    input  logic [PC_W-1:0]       core_pc,
    input  logic [PC_W-1:0]       halt_pc,
`endif
    output logic                  core_reset,
    output logic [REG_ADDR_W-1:0] dbg_reg_addr,
    input  logic [XLEN-1:0]       dbg_reg_data,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic [IDX_W:0]        fail_count,
    output logic [IDX_W-1:0]      first_fail_idx,
    output logic [XLEN-1:0]       first_fail_data,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        CHECK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(NUM_CHECKS - 1);

    state_t                  state;
    logic [NUM_CHECKS-1:0]   tbl_valid;
    logic [REG_ADDR_W-1:0]   tbl_addr [NUM_CHECKS];
    logic [XLEN-1:0]         tbl_data [NUM_CHECKS];
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        ptr_nxt;
    logic [CNT_W-1:0]        hold_cnt;
    logic                    mis;
    logic [IDX_W:0]          fail_nxt;
    logic                    run_end;

    assign ptr_nxt  = ptr + 1'b1;
    assign mis      = tbl_valid[ptr] && (dbg_reg_data != tbl_data[ptr]);
    assign fail_nxt = fail_count + {{IDX_W{1'b0}}, mis};

`ifdef RISCV_SEQ_HALT_PC_EN
    assign run_end = (cycle_count == RUN_LAST) || (core_pc == halt_pc);
`else
    assign run_end = (cycle_count == RUN_LAST);
`endif

    // Table payload needs no reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (state == IDLE && exp_we) begin
            tbl_addr[exp_idx] <= exp_addr;
            tbl_data[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            tbl_valid       <= '0;
            ptr             <= '0;
            hold_cnt        <= '0;
            core_reset      <= 1'b0;
            dbg_reg_addr    <= '0;
            running         <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
            cycle_count     <= '0;
        end else begin
            if (state == IDLE && exp_we)
                tbl_valid[exp_idx] <= exp_valid;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= HOLD;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        hold_cnt        <= '0;
                        cycle_count     <= '0;
                        fail_count      <= '0;
                        first_fail_idx  <= '0;
                        first_fail_data <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        core_reset <= 1'b1;
                        running    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + 1'b1;
                    if (run_end) begin
                        state        <= CHECK;
                        core_reset   <= 1'b0;
                        running      <= 1'b0;
                        ptr          <= '0;
                        dbg_reg_addr <= tbl_addr[0];
                    end
                end
                CHECK: begin
                    fail_count <= fail_nxt;
                    if (mis && fail_count == '0) begin
                        first_fail_idx  <= ptr;
                        first_fail_data <= dbg_reg_data;
                    end
                    if (ptr == PTR_LAST) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        pass         <= (fail_nxt == '0);
                        dbg_reg_addr <= '0;
                    end else begin
                        ptr          <= ptr_nxt;
                        dbg_reg_addr <= tbl_addr[ptr_nxt];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Scoreboard bench for riscv_test_sequencer: directed runs against a register-file model.
// Driver pushes expected results; a negedge monitor measures phases and compares at done.
module tb_riscv_test_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        exp_we;
    logic [3:0]  exp_idx;
    logic        exp_valid;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        core_reset;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;
    logic        running;
    logic        done;
    logic        pass;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail_idx;
    logic [31:0] first_fail_data;
    logic [15:0] cycle_count;
    logic [31:0] regs [32];

`ifdef RISCV_SEQ_HALT_PC_EN
    logic [31:0] core_pc;
    logic [31:0] halt_pc;
    always_ff @(posedge clk or negedge core_reset)
        if (!core_reset) core_pc <= '0;
        else             core_pc <= core_pc + 32'd4;
`endif

    assign dbg_reg_data = regs[dbg_reg_addr];

    riscv_test_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .exp_we          (exp_we),
        .exp_idx         (exp_idx),
        .exp_valid       (exp_valid),
        .exp_addr        (exp_addr),
        .exp_data        (exp_data),
`ifdef RISCV_SEQ_HALT_PC_EN
        .core_pc         (core_pc),
        .halt_pc         (halt_pc),
`endif
        .core_reset      (core_reset),
        .dbg_reg_addr    (dbg_reg_addr),
        .dbg_reg_data    (dbg_reg_data),
        .running         (running),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_idx  (first_fail_idx),
        .first_fail_data (first_fail_data),
        .cycle_count     (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ps;
        logic [4:0]  fc;
        logic [3:0]  fi;
        logic [31:0] fd;
        logic [15:0] cc;
        int          hold;
        int          run;
        int          chk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] i, input logic v,
                        input logic [4:0] a, input logic [31:0] d);
        exp_we    = 1'b1;
        exp_idx   = i;
        exp_valid = v;
        exp_addr  = a;
        exp_data  = d;
        tick();
        exp_we    = 1'b0;
    endtask

    task automatic push(input logic ps, input logic [4:0] fc,
                        input logic [3:0] fi, input logic [31:0] fd,
                        input logic [15:0] cc, input int run);
        exp_t e;
        e.ps = ps; e.fc = fc; e.fi = fi; e.fd = fd;
        e.cc = cc; e.hold = 2; e.run = run; e.chk = 16;
        q.push_back(e);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            tick();
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        tick();
        tick();
    endtask

    task automatic load_base;
        load(4'd0, 1'b1, 5'd1, 32'd5);
        load(4'd1, 1'b1, 5'd2, 32'd10);
        load(4'd2, 1'b1, 5'd3, 32'd15);
        load(4'd3, 1'b1, 5'd4, 32'd5);
    endtask

    // Monitor: phase tracker sampled on the falling edge.
    initial begin
        int   ph;
        int   nh;
        int   nr;
        int   nc;
        exp_t e;
        ph = 0; nh = 0; nr = 0; nc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ph = 0;
            end else begin
                case (ph)
                    0: if (start) begin ph = 1; nh = 0; end
                    1: if (core_reset) begin ph = 2; nr = 1; end
                       else nh++;
                    2: if (running) nr++;
                       else begin ph = 3; nc = 1; end
                    default: begin
                        if (!done) begin
                            nc++;
                        end else begin
                            ph = 0;
                            if (q.size() == 0) begin
                                check("sb_unexpected_done", 32'd1, 32'd0);
                            end else begin
                                e = q.pop_front();
                                check("pass", {31'd0, pass}, {31'd0, e.ps});
                                check("fail_count", {27'd0, fail_count}, {27'd0, e.fc});
                                check("first_fail_idx", {28'd0, first_fail_idx}, {28'd0, e.fi});
                                check("first_fail_data", first_fail_data, e.fd);
                                check("cycle_count", {16'd0, cycle_count}, {16'd0, e.cc});
                                check("hold_cycles", nh, e.hold);
                                check("run_cycles", nr, e.run);
                                check("check_cycles", nc, e.chk);
                            end
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; exp_we = 1'b0;
        exp_idx = '0; exp_valid = 1'b0; exp_addr = '0; exp_data = '0;
`ifdef RISCV_SEQ_HALT_PC_EN
        halt_pc = 32'hFFFF_FFFF;
`endif
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd5; regs[2] = 32'd10; regs[3] = 32'd15;
        regs[4] = 32'd5; regs[9] = 32'd77;
        #3;
        check("rst_core_reset", {31'd0, core_reset}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_fail_count", {27'd0, fail_count}, 32'd0);
        check("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
        check("rst_dbg_addr", {27'd0, dbg_reg_addr}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Load and pass; final entry written in the start cycle.
        load_base();
        push(1'b1, 5'd0, 4'd0, 32'd0, 16'd20, 20);
        exp_we = 1'b1; exp_idx = 4'd4; exp_valid = 1'b1;
        exp_addr = 5'd9; exp_data = 32'd77; start = 1'b1;
        tick();
        exp_we = 1'b0; start = 1'b0;
        wait_done();

        // Single mismatch.
        regs[4] = 32'd6;
        push(1'b0, 5'd1, 4'd3, 32'd6, 16'd20, 20);
        pulse_start();
        wait_done();

        // Multiple mismatches after a fresh reload.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        load_base();
        load(4'd4, 1'b1, 5'd9, 32'd77);
        load(4'd7, 1'b1, 5'd7, 32'h1234);
        regs[4] = 32'd5; regs[2] = 32'd11;
        regs[3] = 32'd16; regs[7] = 32'h1230;
        push(1'b0, 5'd3, 4'd1, 32'd11, 16'd20, 20);
        pulse_start();
        wait_done();

        // Re-run from DONE with corrected values.
        regs[2] = 32'd10; regs[3] = 32'd15; regs[7] = 32'h1234;
        push(1'b1, 5'd0, 4'd0, 32'd0, 16'd20, 20);
        pulse_start();
        check("done_drop", {31'd0, done}, 32'd0);
        wait_done();

        // Writes during RUN and start during CHECK are ignored.
        push(1'b1, 5'd0, 4'd0, 32'd0, 16'd20, 20);
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        load(4'd5, 1'b1, 5'd1, 32'd999);
        load(4'd0, 1'b1, 5'd1, 32'd12345);
        for (int i = 0; i < 40; i++) begin
            if (!running) break;
            tick();
        end
        tick(); tick(); tick();
        pulse_start();
        wait_done();

        // Async reset at run cycle 7, then an empty-table run.
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (cycle_count == 16'd7) break;
            tick();
        end
        check("mid_cycle_reached", {16'd0, cycle_count}, 32'd7);
        #2;
        reset = 1'b0;
        #1;
        check("ar_core_reset", {31'd0, core_reset}, 32'd0);
        check("ar_running", {31'd0, running}, 32'd0);
        check("ar_cycle_count", {16'd0, cycle_count}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        push(1'b1, 5'd0, 4'd0, 32'd0, 16'd20, 20);
        pulse_start();
        wait_done();

`ifdef RISCV_SEQ_HALT_PC_EN
        halt_pc = 32'h20;
        push(1'b1, 5'd0, 4'd0, 32'd0, 16'd9, 9);
        pulse_start();
        wait_done();
        halt_pc = 32'hFFFF_FFFF;
`endif

        tick(); tick();
        check("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_test_sequencer.md
Name: riscv_test_sequencer

Overview:
- Synthesizable, parametrised self-check harness for the single-cycle RISC-V core; replaces fixed-length bench sequencing with hardware.
- Drives the core's active-low reset for a programmable hold time, runs the core for a bounded number of cycles, then reads back registers through a debug read port and compares them to an expected-value table.
- Reports pass/fail, the failure count and the first mismatch.
- Sits beside `riscv_single_cycle` in simulation and FPGA bring-up tops.

Parameters:
- XLEN, 32, data width of register values.
- REG_ADDR_W, 5, register index width.
- NUM_CHECKS, 16, expected-table depth (power of 2, >=2).
- IDX_W, 4, log2(NUM_CHECKS).
- RESET_CYCLES, 2, cycles `core_reset` is held low after start (>=1).
- MAX_CYCLES, 20, run cycles after reset release.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; accepted in IDLE or DONE.
- exp_we  in  1  expected-table write enable.
- exp_idx  in  IDX_W  table entry index.
- exp_valid  in  1  entry is a live check.
- exp_addr  in  REG_ADDR_W  register to check.
- exp_data  in  XLEN  expected value.
- core_reset  out  1  active-low reset to the core.
- dbg_reg_addr  out  REG_ADDR_W  debug read address to the register file.
- dbg_reg_data  in  XLEN  combinational read data for dbg_reg_addr.
- running  out  1  high while the core is out of reset in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 if fail_count==0.
- fail_count  out  IDX_W+1  mismatches found.
- first_fail_idx  out  IDX_W  table index of the first mismatch.
- first_fail_data  out  XLEN  observed value at the first mismatch.
- cycle_count  out  CNT_W  run cycles elapsed.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - core_reset=0, dbg_reg_addr=0.
  - running, done and pass are 0.
  - fail_count, first_fail_idx, first_fail_data and cycle_count are 0.
  - All exp_valid bits are cleared; table data is don't-care.
- IDLE:
  - core_reset=0.
  - exp_we writes the entry at exp_idx on the clock edge; writes in any other state are ignored.
  - start -> HOLD.
  - If start and exp_we are both asserted in the same IDLE cycle, the write lands and start is taken.
- HOLD:
  - core_reset=0 for exactly RESET_CYCLES cycles.
  - On entry, cycle_count, fail_count, first_fail_* and pass are cleared.
  - After the last hold cycle -> RUN.
- RUN:
  - core_reset=1, running=1.
  - cycle_count increments each cycle and saturates at all-ones.
  - When cycle_count==MAX_CYCLES-1 -> CHECK.
  - The core therefore sees exactly MAX_CYCLES rising edges out of reset.
- CHECK:
  - core_reset returns to 0, freezing the core; the register file is unaffected by reset.
  - running=0.
  - The entry pointer i runs 0..NUM_CHECKS-1, one entry per cycle; dbg_reg_addr = entry[i].addr.
  - If entry[i].valid and dbg_reg_data != entry[i].data:
    - fail_count increments.
    - If this is the first mismatch, first_fail_idx=i and first_fail_data=dbg_reg_data are captured.
  - Invalid entries consume a cycle but never count.
  - After i=NUM_CHECKS-1 -> DONE.
  - Total CHECK latency is NUM_CHECKS cycles.
- DONE:
  - done=1; pass=(fail_count==0).
  - Results are held stable.
  - start -> HOLD (re-run; table retained); done drops the cycle after start.
- start in HOLD, RUN or CHECK is ignored.
- Checking register 0 expects 0; no special-casing.
- fail_count cannot overflow: its width is IDX_W+1.
- Async reset mid-RUN or mid-CHECK:
  - Immediate IDLE, core_reset=0, table valids cleared.
  - A new start requires the table to be reloaded.

Optional Feature:
- Macro: RISCV_SEQ_HALT_PC_EN.
- When defined:
  - Adds parameter PC_W (32) and ports `core_pc` (in, PC_W) and `halt_pc` (in, PC_W).
  - In RUN, if core_pc==halt_pc on a cycle, the transition to CHECK happens at the end of that cycle.
  - cycle_count holds the cycles consumed.
  - MAX_CYCLES remains the timeout.
- When undefined: ports are absent and RUN always lasts MAX_CYCLES.

Test Plan:
- Expected-value load and pass:
  - Load entries {1:5, 2:10, 3:15, 4:5, 9:77} (indices 0-4), others invalid; the core model produces those values.
  - start -> core_reset low exactly 2 cycles, running 20 cycles, done after 16 CHECK cycles.
  - Expect pass=1, fail_count=0, cycle_count=20.
- Single mismatch:
  - Entry 3 expects x4=5, the model returns 6.
  - Expect pass=0, fail_count=1, first_fail_idx=3, first_fail_data=6.
- Multiple mismatches:
  - Entries 1, 2 and 7 mismatch.
  - Expect fail_count=3, first_fail_idx=1.
  - Issue start from DONE; the re-run with corrected model values gives pass=1 (table retained).
- Ignored stimulus:
  - exp_we during RUN does not change the table.
  - start during CHECK is ignored.
  - Results are identical to the undisturbed run.
- Async reset mid-operation:
  - reset=0 mid-RUN (cycle 7).
  - Expect immediate core_reset=0, running=0, cycle_count=0.
  - A start after reset with no reload gives pass=1, fail_count=0 (all entries invalid).
- Halt on PC (with RISCV_SEQ_HALT_PC_EN):
  - Set halt_pc=0x20; the model reaches 0x20 on run cycle 9.
  - Expect CHECK entered after 9 run cycles, cycle_count=9.
